// File: rtl/regfile_wr_arbiter_if.sv
// regfile_wr_arbiter_if -- bundles the two writeback requester handshakes and
// the arbitrated register-file write port.
//   req0_*/req1_* : requester offers (valid/regnum/data) and ready back
//   wr_*          : single write port toward mips_regfile
//   pend_mask     : registers targeted by a held write
//   grant         : requester owning the current write slot
// Modports: master = requester/observer side, slave = arbiter side.
interface regfile_wr_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic [4:0]       req0_regnum;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [4:0]       req1_regnum;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic             wr_enable;
  logic [4:0]       wr_regnum;
  logic [WIDTH-1:0] wr_data;
  logic [31:0]      pend_mask;
  logic             grant;

  modport master (
    output req0_valid, req0_regnum, req0_data,
    output req1_valid, req1_regnum, req1_data,
    input  req0_ready, req1_ready,
    input  wr_enable, wr_regnum, wr_data, pend_mask, grant
  );

  modport slave (
    input  req0_valid, req0_regnum, req0_data,
    input  req1_valid, req1_regnum, req1_data,
    output req0_ready, req1_ready,
    output wr_enable, wr_regnum, wr_data, pend_mask, grant
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter -- merges ALU (requester 0) and load (requester 1)
// writebacks onto the single mips_regfile write port. Each requester owns a
// one-entry slot; one full slot is granted per cycle and drives the write port
// combinationally. Contested cycles are round-robin by default.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset (0 = reset)
//   bus   : regfile_wr_arbiter_if.slave (requester handshakes, write port,
//           pend_mask, grant)
// Configuration macro: RF_ARB_FIXED_PRIO_EN -- when defined, requester 1
// always wins a contested cycle and the priority pointer stays at 0.
module regfile_wr_arbiter #(
  parameter int WIDTH = 32
) (
  input logic                 clk,
  input logic                 reset,
  regfile_wr_arbiter_if.slave bus
);

  // One-hot decode of a held slot's destination register.
  function automatic logic [31:0] reg_decode(input logic full, input logic [4:0] regnum);
    logic [31:0] onehot_v;
    onehot_v = 32'd1 << regnum;
    return full ? onehot_v : 32'd0;
  endfunction

  logic             run_r;
  logic             full0_r;
  logic [4:0]       regnum0_r;
  logic [WIDTH-1:0] data0_r;
  logic             full1_r;
  logic [4:0]       regnum1_r;
  logic [WIDTH-1:0] data1_r;
  logic             ptr_r;

  logic             gnt_s;
  logic             any_full_s;
  logic             contested_s;
  logic             ready0_s;
  logic             ready1_s;
  logic             acc0_s;
  logic             acc1_s;
  logic [4:0]       sel_regnum_s;
  logic [WIDTH-1:0] sel_data_s;
  logic [31:0]      mask_s;

  // Pick the slot served this cycle; gnt_s=1 selects requester 1.
  always_comb begin
    contested_s = full0_r & full1_r;
    any_full_s  = full0_r | full1_r;
    if (contested_s) begin
`ifdef RF_ARB_FIXED_PRIO_EN
      gnt_s = 1'b1;
`else
      gnt_s = ptr_r;
`endif
    end else begin
      gnt_s = full1_r;
    end
  end

  // A slot can take an offer when empty or when it drains this cycle.
  // run_r keeps ready low on the edge where reset is released.
  always_comb begin
    ready0_s = run_r & (~full0_r | ~gnt_s);
    ready1_s = run_r & (~full1_r | gnt_s);
    acc0_s   = bus.req0_valid & ready0_s;
    acc1_s   = bus.req1_valid & ready1_s;
  end

  // Write port and status outputs, all derived from slot state.
  always_comb begin
    if (gnt_s) begin
      sel_regnum_s = regnum1_r;
      sel_data_s   = data1_r;
    end else begin
      sel_regnum_s = regnum0_r;
      sel_data_s   = data0_r;
    end
    mask_s    = reg_decode(full0_r, regnum0_r) | reg_decode(full1_r, regnum1_r);
    mask_s[0] = 1'b0;
    if (any_full_s) begin
      bus.wr_enable = (sel_regnum_s != 5'd0);
      bus.wr_regnum = sel_regnum_s;
      bus.wr_data   = sel_data_s;
      bus.grant     = gnt_s;
    end else begin
      bus.wr_enable = 1'b0;
      bus.wr_regnum = 5'd0;
      bus.wr_data   = {WIDTH{1'b0}};
      bus.grant     = 1'b0;
    end
    bus.pend_mask  = mask_s;
    bus.req0_ready = ready0_s;
    bus.req1_ready = ready1_s;
  end

  // Run flag: set on the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_r <= 1'b0;
    end else begin
      run_r <= 1'b1;
    end
  end

  // Slot 0: load on accept, otherwise empty once granted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full0_r   <= 1'b0;
      regnum0_r <= 5'd0;
      data0_r   <= {WIDTH{1'b0}};
    end else if (acc0_s) begin
      full0_r   <= 1'b1;
      regnum0_r <= bus.req0_regnum;
      data0_r   <= bus.req0_data;
    end else if (full0_r && !gnt_s) begin
      full0_r   <= 1'b0;
    end else begin
      full0_r   <= full0_r;
    end
  end

  // Slot 1: load on accept, otherwise empty once granted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full1_r   <= 1'b0;
      regnum1_r <= 5'd0;
      data1_r   <= {WIDTH{1'b0}};
    end else if (acc1_s) begin
      full1_r   <= 1'b1;
      regnum1_r <= bus.req1_regnum;
      data1_r   <= bus.req1_data;
    end else if (full1_r && gnt_s) begin
      full1_r   <= 1'b0;
    end else begin
      full1_r   <= full1_r;
    end
  end

  // Priority pointer: flips to the loser after each contested grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_r <= 1'b0;
    end else begin
`ifdef RF_ARB_FIXED_PRIO_EN
      ptr_r <= 1'b0;
`else
      if (contested_s) begin
        ptr_r <= ~gnt_s;
      end else begin
        ptr_r <= ptr_r;
      end
`endif
    end
  end

endmodule
